// File: rtl/fetch_pcreg_pkg.sv
// Shared types and constants for the fetch-stage PC register.
// Holds the fetch FSM state encoding and the instruction-bus request/response structs.
// No logic; imported by fetch_pcreg.
package fetch_pcreg_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [63:0] PC_STEP          = 64'd4;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/fetch_pcreg.sv
// Fetch PC owner: issues one instruction-bus request at a time and hands the word to decode.
// Latency: bus latency + 2 cycles per instruction; no prefetch.
// Backpressure: HOLD keeps out_* stable until out_ready; redirects cancel or drain the fetch.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned PCs skip the bus and deliver a NOP with out_misalign.
module fetch_pcreg
  import fetch_pcreg_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_nxt,
  input  logic        jump_flag,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        out_misalign
`endif
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  req_pc_q, req_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         fetch_misaligned;
  ibus_req_t    ireq;
  ibus_resp_t   iresp;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign fetch_misaligned = (req_pc_q[1:0] != 2'b00);
`else
  assign fetch_misaligned = 1'b0;
`endif

  assign iresp.data_ok = iresp_data_ok;
  assign iresp.data    = iresp_data;

  // Next-state and PC datapath: redirects always overwrite pc; req_pc only moves when the bus is free.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    instr_d  = instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      FETCH: begin
        if (fetch_misaligned) begin
          // No bus transaction exists, so a redirect can be taken immediately.
          if (jump_flag) begin
            pc_d     = pc_nxt;
            req_pc_d = pc_nxt;
          end else begin
            instr_d = NOP_INSTR;
            state_d = HOLD;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_d = 1'b1;
`endif
          end
        end else if (iresp.data_ok) begin
          if (jump_flag) begin
            pc_d     = pc_nxt;
            req_pc_d = pc_nxt;
          end else begin
            instr_d = iresp.data;
            state_d = HOLD;
          end
        end else if (jump_flag) begin
          // Request already on the bus: remember the target and wait for it to complete.
          pc_d    = pc_nxt;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (iresp.data_ok) begin
          state_d  = FETCH;
          pc_d     = jump_flag ? pc_nxt : pc_q;
          req_pc_d = jump_flag ? pc_nxt : pc_q;
        end else if (jump_flag) begin
          pc_d = pc_nxt;
        end
      end
      HOLD: begin
        if (jump_flag) begin
          pc_d     = pc_nxt;
          req_pc_d = pc_nxt;
          state_d  = FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
          misalign_d = 1'b0;
`endif
        end else if (out_ready) begin
          pc_d     = req_pc_q + PC_STEP;
          req_pc_d = req_pc_q + PC_STEP;
          state_d  = FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
          misalign_d = 1'b0;
`endif
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      instr_q  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      instr_q  <= instr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Bus request decode: valid while a transaction is live, silenced during reset.
  always_comb begin
    ireq.valid = !reset && (((state_q == FETCH) && !fetch_misaligned) || (state_q == DRAIN));
    ireq.addr  = req_pc_q;
  end

  assign ireq_valid = ireq.valid;
  assign ireq_addr  = ireq.addr;

  // A same-cycle redirect kills the decode handoff.
  assign out_valid = !reset && (state_q == HOLD) && !jump_flag;
  assign out_pc    = req_pc_q;
  assign out_instr = instr_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign out_misalign = !reset && (state_q == HOLD) && misalign_q;
`endif

endmodule

// File: tb/tb_fetch_pcreg.sv
module tb_fetch_pcreg;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] NOJ    = 64'hDEAD_BEEF_DEAD_BEE1;
  localparam logic [31:0] JUNK   = 32'hBAD0_BAD0;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [63:0] pc_nxt;
  logic        jump_flag;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        out_misalign;
`endif

  fetch_pcreg dut (
    .clk(clk), .reset(reset), .pc_nxt(pc_nxt), .jump_flag(jump_flag),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .out_misalign(out_misalign)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one bus request slot, one decode buffer slot.
  bit          m_req_vld, m_dead, m_buf_vld, m_buf_mis;
  logic [63:0] m_req_addr, m_tgt, m_buf_pc;
  logic [31:0] m_buf_instr;

  function automatic bit m_mis_now();
    return MIS_EN && m_req_vld && !m_dead && (m_req_addr[1:0] != 2'b00);
  endfunction

  task automatic m_new_req(input logic [63:0] a);
    m_req_vld = 1; m_req_addr = a; m_dead = 0;
  endtask

  task automatic m_reset();
    m_new_req(RST_PC);
    m_buf_vld = 0; m_buf_mis = 0;
  endtask

  task automatic m_advance();
    if (reset) begin
      m_reset();
    end else if (m_buf_vld) begin
      if (jump_flag)      begin m_buf_vld = 0; m_new_req(pc_nxt); end
      else if (out_ready) begin m_buf_vld = 0; m_new_req(m_buf_pc + 64'd4); end
    end else if (m_mis_now()) begin
      if (jump_flag) m_new_req(pc_nxt);
      else begin
        m_req_vld = 0; m_buf_vld = 1; m_buf_pc = m_req_addr;
        m_buf_instr = 32'h0000_0013; m_buf_mis = 1;
      end
    end else if (m_req_vld) begin
      if (iresp_data_ok) begin
        if (jump_flag)   m_new_req(pc_nxt);
        else if (m_dead) m_new_req(m_tgt);
        else begin
          m_req_vld = 0; m_buf_vld = 1; m_buf_pc = m_req_addr;
          m_buf_instr = iresp_data; m_buf_mis = 0;
        end
      end else if (jump_flag) begin
        m_dead = 1; m_tgt = pc_nxt;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic jmp, input logic [63:0] nxt,
                       input logic dok, input logic [31:0] dat, input logic rdy);
    reset = rst; jump_flag = jmp; pc_nxt = nxt;
    iresp_data_ok = dok; iresp_data = dat; out_ready = rdy;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    m_advance();
    #1;
  endtask

  task automatic check_model();
    logic e_iv, e_ov;
    e_iv = !reset && m_req_vld && !m_mis_now();
    e_ov = !reset && m_buf_vld && !jump_flag;
    chk("rnd_ireq_valid", {63'd0, ireq_valid}, {63'd0, e_iv});
    if (e_iv) chk("rnd_ireq_addr", ireq_addr, m_req_addr);
    chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, e_ov});
    if (e_ov) begin
      chk("rnd_out_pc", out_pc, m_buf_pc);
      chk("rnd_out_instr", {32'd0, out_instr}, {32'd0, m_buf_instr});
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rnd_out_misalign", {63'd0, out_misalign}, {63'd0, m_buf_mis});
`endif
    end
  endtask

  typedef struct {
    logic        rst, jmp;
    logic [63:0] nxt;
    logic        dok;
    logic [31:0] dat;
    logic        rdy;
    logic        e_iv;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic jmp, input logic [63:0] nxt,
                     input logic dok, input logic [31:0] dat, input logic rdy,
                     input logic e_iv, input logic [63:0] e_addr,
                     input logic e_ov, input logic [63:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.rst = rst; v.jmp = jmp; v.nxt = nxt; v.dok = dok; v.dat = dat; v.rdy = rdy;
    v.e_iv = e_iv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr;
    tbl.push_back(v);
  endtask

  initial begin
    // rst jmp nxt dok dat rdy | iv addr ov pc instr
    add(1, 0, NOJ, 0, 0, 0,            0, 0, 0, 0, 0);
    add(0, 0, NOJ, 1, 32'h1111_0113, 0, 1, 64'h8000_0000, 0, 0, 0);
    add(0, 0, NOJ, 0, JUNK, 1,         0, 0, 1, 64'h8000_0000, 32'h1111_0113);
    add(0, 0, NOJ, 1, 32'h2222_0113, 0, 1, 64'h8000_0004, 0, 0, 0);
    add(0, 0, NOJ, 0, JUNK, 1,         0, 0, 1, 64'h8000_0004, 32'h2222_0113);
    add(0, 0, NOJ, 1, 32'h3333_0113, 0, 1, 64'h8000_0008, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, NOJ, 0, JUNK, 0,       0, 0, 1, 64'h8000_0008, 32'h3333_0113);
    add(0, 0, NOJ, 0, JUNK, 1,         0, 0, 1, 64'h8000_0008, 32'h3333_0113);
    add(0, 1, 64'h8000_1000, 0, JUNK, 0, 1, 64'h8000_000C, 0, 0, 0);
    add(0, 0, NOJ, 0, JUNK, 0,         1, 64'h8000_000C, 0, 0, 0);
    add(0, 0, NOJ, 1, JUNK, 0,         1, 64'h8000_000C, 0, 0, 0);
    add(0, 0, NOJ, 1, 32'h4444_0113, 1, 1, 64'h8000_1000, 0, 0, 0);
    add(0, 1, 64'h8000_0200, 0, JUNK, 1, 0, 0, 0, 0, 0);
    add(0, 1, 64'h8000_0300, 0, JUNK, 0, 1, 64'h8000_0200, 0, 0, 0);
    add(0, 1, 64'h8000_0400, 0, JUNK, 0, 1, 64'h8000_0200, 0, 0, 0);
    add(0, 0, NOJ, 1, JUNK, 0,         1, 64'h8000_0200, 0, 0, 0);
    add(0, 0, NOJ, 1, 32'h5555_0113, 0, 1, 64'h8000_0400, 0, 0, 0);
    add(0, 0, NOJ, 0, JUNK, 1,         0, 0, 1, 64'h8000_0400, 32'h5555_0113);
    add(0, 1, 64'h8000_0500, 1, JUNK, 0, 1, 64'h8000_0404, 0, 0, 0);
    add(0, 0, NOJ, 0, JUNK, 1,         1, 64'h8000_0500, 0, 0, 0);
    add(1, 0, NOJ, 0, JUNK, 1,         0, 0, 0, 0, 0);
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, JUNK, 0, 1, 64'h8000_0000, 0, 0, 0);
    add(0, 0, NOJ, 1, 32'h6666_0113, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
    add(0, 0, NOJ, 0, JUNK, 1,         0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h6666_0113);
    add(0, 0, NOJ, 0, JUNK, 0,         1, 64'h0, 0, 0, 0);
    add(0, 1, 64'h8000_0600, 0, JUNK, 0, 1, 64'h0, 0, 0, 0);
    add(0, 1, 64'h8000_0700, 1, JUNK, 0, 1, 64'h0, 0, 0, 0);
    add(0, 0, NOJ, 0, JUNK, 0,         1, 64'h8000_0700, 0, 0, 0);

    // Initial reset cycle aligns the bench to the clock.
    reset = 1; jump_flag = 0; pc_nxt = NOJ; iresp_data_ok = 0; iresp_data = 0; out_ready = 0;
    m_reset();
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].jmp, tbl[i].nxt, tbl[i].dok, tbl[i].dat, tbl[i].rdy);
      chk($sformatf("v%0d_ireq_valid", i), {63'd0, ireq_valid}, {63'd0, tbl[i].e_iv});
      if (tbl[i].e_iv) chk($sformatf("v%0d_ireq_addr", i), ireq_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_ov});
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d_out_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_out_instr", i), {32'd0, out_instr}, {32'd0, tbl[i].e_instr});
      end
      tick();
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Redirect to a misaligned PC: no bus request, NOP delivered with out_misalign.
    drive(0, 0, NOJ, 1, 32'h7777_0113, 0);
    chk("mis_pre_addr", ireq_addr, 64'h8000_0700);
    tick();
    drive(0, 1, 64'h8000_0002, 0, JUNK, 1);
    chk("mis_kill_ov", {63'd0, out_valid}, 64'd0);
    tick();
    drive(0, 0, NOJ, 0, JUNK, 0);
    chk("mis_no_req", {63'd0, ireq_valid}, 64'd0);
    tick();
    drive(0, 0, NOJ, 0, JUNK, 0);
    chk("mis_ov", {63'd0, out_valid}, 64'd1);
    chk("mis_flag", {63'd0, out_misalign}, 64'd1);
    chk("mis_instr", {32'd0, out_instr}, 64'h0000_0013);
    chk("mis_pc", out_pc, 64'h8000_0002);
    drive(0, 0, NOJ, 0, JUNK, 1);
    tick();
    drive(0, 0, NOJ, 0, JUNK, 0);
    chk("mis_clear", {63'd0, out_misalign}, 64'd0);
    chk("mis_no_req2", {63'd0, ireq_valid}, 64'd0);
    tick();
    drive(0, 1, 64'h8000_0800, 0, JUNK, 0);
    tick();
    drive(0, 0, NOJ, 0, JUNK, 0);
    chk("mis_recover_addr", ireq_addr, 64'h8000_0800);
    chk("mis_recover_iv", {63'd0, ireq_valid}, 64'd1);
    tick();
`endif

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      logic        r_rst, r_jmp, r_dok, r_rdy;
      logic [63:0] r_nxt;
      r_rst = ($urandom_range(0, 199) == 0);
      r_jmp = ($urandom_range(0, 5) == 0);
      r_nxt = {$urandom, $urandom};
      if (MIS_EN && ($urandom_range(0, 3) != 0)) r_nxt[1:0] = 2'b00;
      r_dok = m_req_vld && !m_mis_now() && ($urandom_range(0, 2) == 0);
      r_rdy = $urandom_range(0, 1) == 1;
      drive(r_rst, r_jmp, r_jmp ? r_nxt : {$urandom, $urandom}, r_dok, $urandom, r_rdy);
      check_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
